// File: rtl/mul_ctrl_pkg.sv
// Shared types for the multiplier issue controller: op encoding, shadow-slot layout
// and pipeline depth of the attached Booth/Wallace multiplier.
package mul_ctrl_pkg;

    localparam int MUL_LAT    = 3;
    localparam int NREQ       = 2;
    localparam int SLOT_TAG_W = 4;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef struct packed {
        logic                  valid;
        logic                  id;
        mul_op_e               op;
        logic [SLOT_TAG_W-1:0] tag;
        logic [31:0]           corr;
    } mul_slot_t;

endpackage

// File: rtl/mul_issue_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the favoured index moves to the loser after every grant.
module rr_arb2
    import mul_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);

    logic prio;

    always_comb begin
        gnt = '0;
        if (advance) begin
            if (req[prio]) begin
                gnt[prio] = 1'b1;
            end else if (req[~prio]) begin
                gnt[~prio] = 1'b1;
            end
        end
    end

    // granting 0 favours 1 next time, granting 1 favours 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (|gnt) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller for the 3-stage signed 32x32 multiplier: arbitrates two RV32M requesters,
// shadows in-flight ops and turns the signed product into MUL/MULH/MULHSU/MULHU results.
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TAG_W = SLOT_TAG_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [32*NREQ-1:0]      req_a,
    input  logic [32*NREQ-1:0]      req_b,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [TAG_W*NREQ-1:0]   req_tag,
    output logic                    mul_en,
    output logic [31:0]             mul_a,
    output logic [31:0]             mul_b,
    input  logic signed [63:0]      mul_p,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [31:0]             rsp_data
);

    // Term added to the signed high word to reinterpret either operand as unsigned.
    function automatic logic [31:0] hi_corr(input mul_op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] corr_b;
        logic [31:0] corr_a;
        corr_b = b[31] ? a : 32'd0;
        corr_a = a[31] ? b : 32'd0;
        case (op)
            MULHSU:  hi_corr = corr_b;
            MULHU:   hi_corr = corr_b + corr_a;
            default: hi_corr = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rsp_word(input mul_slot_t s, input logic signed [63:0] p);
        if (!s.valid) begin
            rsp_word = 32'd0;
        end else if (s.op == MUL) begin
            rsp_word = p[31:0];
        end else begin
            rsp_word = p[63:32] + s.corr;
        end
    endfunction

    logic [NREQ-1:0] gnt;
    logic            issue;
    logic            win;
    mul_slot_t       slot_in;
    mul_slot_t       slot_p [MUL_LAT];

    assign mul_en = !(slot_p[MUL_LAT-1].valid && !rsp_ready);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (mul_en),
        .gnt     (gnt)
    );

    assign req_ready = gnt;
    assign issue     = |gnt;
    assign win       = gnt[1];

    // Issue: winner's operands go to the multiplier; no grant drives zeros and a bubble
    always_comb begin
        slot_in = '0;
        mul_a   = 32'd0;
        mul_b   = 32'd0;
        if (issue) begin
            mul_a         = req_a[32*int'(win) +: 32];
            mul_b         = req_b[32*int'(win) +: 32];
            slot_in.valid = 1'b1;
            slot_in.id    = win;
            slot_in.op    = mul_op_e'(req_op[2*int'(win) +: 2]);
            slot_in.tag   = SLOT_TAG_W'(req_tag[TAG_W*int'(win) +: TAG_W]);
            slot_in.corr  = hi_corr(slot_in.op, mul_a, mul_b);
        end
    end

    // Shadow stages p0..p2 track the multiplier's operand, partial-product and product registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                slot_p[i] <= '0;
            end
        end else if (mul_en) begin
            slot_p[0] <= slot_in;
            for (int i = 1; i < MUL_LAT; i++) begin
                slot_p[i] <= slot_p[i-1];
            end
        end
    end

    // Response: straight from the product-aligned stage
    assign rsp_valid = slot_p[MUL_LAT-1].valid;
    assign rsp_id    = slot_p[MUL_LAT-1].id;
    assign rsp_tag   = TAG_W'(slot_p[MUL_LAT-1].tag);
    assign rsp_data  = rsp_word(slot_p[MUL_LAT-1], mul_p);

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Issue controller and two-requester arbiter for the 3-stage pipelined signed 32x32 Booth/Wallace multiplier in the RISC-V PE. It accepts RV32M multiply requests (MUL, MULH, MULHSU, MULHU) from two requesters over valid/ready, drives the multiplier's operands and `en`, and tracks the in-flight ops. It also applies the unsigned high-word correction to the signed product and returns tagged 32-bit results with backpressure.

## Interface
- TAG_W, 4: requester tag width carried through to the response.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; a transfer happens on `valid && ready`.
- req_a, req_b  in  2x32 (flat 64)  rs1/rs2 bit patterns; requester i uses `[32*i +: 32]`.
- req_op  in  2x2 (flat 4)  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- req_tag  in  2xTAG_W (flat)  opaque tag.
- mul_en  out  1  multiplier pipeline enable.
- mul_a, mul_b  out  32  multiplier operands.
- mul_p  in  64  multiplier signed product.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  1  requester index.
- rsp_tag  out  TAG_W  returned tag.
- rsp_data  out  32  result.

## Operation
- Shadow pipeline: the controller holds 3 slots, S0, S1 and S2. They align with the multiplier's operand register, partial-product register and product register.
- Each slot holds valid, id, op, tag and a 32-bit correction term `corr`.
- The whole shadow pipeline advances only when `mul_en`=1.
- `mul_en = !(S2.valid && !rsp_ready)`. A stalled result freezes the multiplier and the shadow pipeline together.
- Arbitration is round-robin over 2 requesters. Pointer `prio` selects the favoured requester.
- Grant: the winner is the favoured requester if it is valid, otherwise the other one. A grant happens only if `mul_en`=1.
- `req_ready[i]` = (grant to i). At most one bit is high.
- On a grant, `prio` flips to the non-granted index. With no grant, `prio` holds.
- `mul_a`/`mul_b` carry the winner's operands. With no grant they carry zero, and S0 loads valid=0 (a bubble).
- `corr` is computed at issue, modulo 2^32:
  - MUL and MULH: 0.
  - MULHSU: `b[31] ? a : 0`.
  - MULHU: `(a[31] ? b : 0) + (b[31] ? a : 0)`.
- Response is taken from S2:
  - `rsp_valid` = S2.valid; `rsp_id` and `rsp_tag` come from S2.
  - MUL: `rsp_data = mul_p[31:0]`.
  - All other ops: `rsp_data = mul_p[63:32] + S2.corr`, modulo 2^32.
- A bubble in S2 with `rsp_ready`=0 does not stall.
- The multiplier's own `valid` output is unused.
- Integration connects the multiplier reset to `~rst_n`.

## Timing
- Reset (async assert, sync release):
  - All slots invalid, `prio`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_tag`=0, `rsp_data`=0.
  - `mul_en`=1, `mul_a`=`mul_b`=0, `req_ready`=0.
- Latency: a request accepted in cycle c gives `rsp_valid` in cycle c+3, provided no stall occurs. Each stall cycle adds exactly 1 cycle.
- Throughput: 1 op/cycle sustained.
- Both requesters valid continuously: grants alternate 0,1,0,1…
- Stall: while `rsp_valid && !rsp_ready`, `req_ready`=00. S2 and `rsp_*` hold stable, and no slot changes.
- Response accepted and a new request granted in the same cycle: both happen, with no bubble inserted.
- Reset mid-operation: all in-flight ops are discarded, no response is produced for them, and the requesters must reissue.
- Requester inputs may change while not granted. They are not required to stay stable.

## Structure
- Package `mul_ctrl_pkg`:
  - op enum `mul_op_e` (MUL/MULH/MULHSU/MULHU).
  - `MUL_LAT`=3.
  - `NREQ`=2.
  - packed slot struct `mul_slot_t` {valid, id, op, tag, corr}.
- Sub-module `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: clk, rst_n, req[1:0], advance.
  - Output: gnt[1:0] (one-hot or zero).
  - Owns `prio`.

## Test plan
- Reset, then requester 0 sends MUL with a=7, b=-3, tag=5. Expected: `rsp_valid` exactly 3 cycles after the grant, with rsp_data=0xFFFFFFEB, id=0, tag=5.
- a=b=0xFFFFFFFF with op MULH, then MULHSU, then MULHU, back to back from requester 1. Expected results on consecutive cycles: 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE.
- Both requesters valid for 6 cycles. Expected: grants 0,1,0,1,0,1, responses in the same order with the matching tags, and no bubbles.
- Hold `rsp_ready`=0 for 4 cycles with 3 ops in flight. Expected: `mul_en`=0, `req_ready`=00, and `rsp_*` stable during the stall. After release, all 3 results arrive on consecutive cycles, unmodified and in order.
- Assert `rst_n`=0 for 1 cycle with 2 ops in flight. Expected: `rsp_valid`=0 immediately, no stale response afterwards, and the next request returns a correct result after 3 cycles.
- Random mix of ops, operands and backpressure against a 64-bit reference model. Expected: every result and tag matches.
